// File: rtl/wb_host_slice.sv
// wb_host_slice: registered Wishbone slice between the Caravel management port
// and interconnect master 0, with a bus-timeout watchdog.
// FSM: IDLE -> REQ -> RESP -> IDLE, one outstanding classic-WB cycle.
// Optional feature macro: WB_HOST_SLICE_STATS_EN adds timeout statistics
// outputs (to_cnt_o, to_adr_o, to_irq_o). Without it the FSM is unchanged.
module wb_host_slice #(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter int              TIMEOUT_CYC = 255,
    parameter logic [DW-1:0]   ERR_DATA    = DW'(32'hDEAD_BEEF)
) (
    input  logic               wb_clk_i,
    input  logic               rst_n,
    // upstream (SoC)
    input  logic               wbm_cyc_i,
    input  logic               wbm_stb_i,
    input  logic               wbm_we_i,
    input  logic [DW/8-1:0]    wbm_sel_i,
    input  logic [AW-1:0]      wbm_adr_i,
    input  logic [DW-1:0]      wbm_dat_i,
    output logic [DW-1:0]      wbm_dat_o,
    output logic               wbm_ack_o,
    output logic               wbm_err_o,
    // downstream (interconnect m0)
    output logic               wbs_cyc_o,
    output logic               wbs_stb_o,
    output logic               wbs_we_o,
    output logic [DW/8-1:0]    wbs_sel_o,
    output logic [AW-1:0]      wbs_adr_o,
    output logic [DW-1:0]      wbs_dat_o,
    input  logic [DW-1:0]      wbs_dat_i,
    input  logic               wbs_ack_i
`ifdef WB_HOST_SLICE_STATS_EN
    ,
    output logic [15:0]        to_cnt_o,
    output logic [AW-1:0]      to_adr_o,
    output logic               to_irq_o
`endif
);

    // Counter only needs to reach TIMEOUT_CYC-1.
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // Request/response FSM; every output is a register written here.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            wbs_sel_o <= '0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
`ifdef WB_HOST_SLICE_STATS_EN
            to_cnt_o  <= '0;
            to_adr_o  <= '0;
            to_irq_o  <= 1'b0;
`endif
        end else begin
            // ack/err/irq are single-cycle pulses by default
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
`ifdef WB_HOST_SLICE_STATS_EN
            to_irq_o  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        wbs_we_o  <= wbm_we_i;
                        wbs_sel_o <= wbm_sel_i;
                        wbs_adr_o <= wbm_adr_i;
                        wbs_dat_o <= wbm_dat_i;
                        wbs_cyc_o <= 1'b1;
                        wbs_stb_o <= 1'b1;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (!wbm_cyc_i) begin
                        // master abandoned the cycle: release the bus silently
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        state     <= IDLE;
                    end else if (wbs_ack_i) begin
                        // ack beats a coincident timeout
                        wbm_dat_o <= wbs_dat_i;
                        wbm_ack_o <= 1'b1;
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        wbm_dat_o <= ERR_DATA;
                        wbm_ack_o <= 1'b1;
                        wbm_err_o <= 1'b1;
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        state     <= RESP;
`ifdef WB_HOST_SLICE_STATS_EN
                        to_irq_o  <= 1'b1;
                        to_adr_o  <= wbs_adr_o;
                        if (to_cnt_o != 16'hFFFF)
                            to_cnt_o <= to_cnt_o + 16'd1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // ack is visible this cycle; master's lingering strobe is ignored
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
